// File: rtl/seq_seg_adder.sv
// seq_seg_adder: multi-cycle adder that sums two DATA_W-bit operands plus
// carry-in, SEG_W bits per clock, with the carry held in a register between
// segments. Valid/ready handshake on both the operand and the result side.
//
// Optional feature: define SEQ_SEG_ADDER_OVF_EN to add the 'ovf' output
// (two's-complement signed overflow of a+b+cin, valid with out_valid).
//
// DATA_W must be a multiple of SEG_W, and 1 <= SEG_W <= DATA_W.

module seq_seg_adder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEG_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
`ifdef SEQ_SEG_ADDER_OVF_EN
  output logic              ovf,
`endif
  output logic              cout
);

  localparam int unsigned NSEG  = DATA_W / SEG_W;
  localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned LAST  = NSEG - 1;
  localparam int unsigned MSB   = DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_d;
  logic              cout_d;
  logic              out_valid_d;
`ifdef SEQ_SEG_ADDER_OVF_EN
  logic              ovf_d;
`endif

  int unsigned       seg_base;
  logic [SEG_W-1:0]  a_seg;
  logic [SEG_W-1:0]  b_seg;
  logic [SEG_W:0]    seg_res;
  logic              last_seg;

  // Ready is decoded from state alone so there is no in_valid -> in_ready path.
  assign in_ready = (state_q == IDLE);

  // Slice adder: current segment of both operands plus the held carry.
  always_comb begin
    seg_base = 32'(cnt_q) * SEG_W;
    a_seg    = a_q[seg_base +: SEG_W];
    b_seg    = b_q[seg_base +: SEG_W];
    seg_res  = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_W+1)'(carry_q);
    last_seg = (cnt_q == CNT_W'(LAST));
  end

  // Next-state and datapath updates for the accept / add / hold sequence.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum;
    cout_d      = cout;
    out_valid_d = out_valid;
`ifdef SEQ_SEG_ADDER_OVF_EN
    ovf_d       = ovf;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        sum_d[seg_base +: SEG_W] = seg_res[SEG_W-1:0];
        carry_d                  = seg_res[SEG_W];
        if (last_seg) begin
          // The last segment holds the MSB, so its result finishes the sum.
          cout_d      = seg_res[SEG_W];
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SEQ_SEG_ADDER_OVF_EN
          ovf_d       = (a_q[MSB] == b_q[MSB]) && (seg_res[SEG_W-1] != a_q[MSB]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, carry, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SEQ_SEG_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum       <= sum_d;
      cout      <= cout_d;
      out_valid <= out_valid_d;
`ifdef SEQ_SEG_ADDER_OVF_EN
      ovf       <= ovf_d;
`endif
    end
  end

endmodule
